// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side streamer: buffer occupancy states and beat-width helper.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } cnt_st_t;

    // Burst lengths of 1 would give a zero-width counter, so clamp to one bit.
    function automatic int beat_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream; the optional parity bit exists only with FIFO_RD_PARITY_EN.
interface fifo_rd_stream_if #(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 8
);
    import fifo_rd_pkg::*;

    localparam int BEAT_W = beat_w(BURST_LEN);

    logic [DSIZE-1:0]  rdata;
    logic              rempty;
    logic              rinc;
    logic [DSIZE-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [BEAT_W-1:0] out_beat;

`ifdef FIFO_RD_PARITY_EN
    logic              out_par;

    modport master (
        input  rdata, rempty, out_ready,
        output rinc, out_data, out_valid, out_last, out_beat, out_par
    );
    modport slave (
        output rdata, rempty, out_ready,
        input  rinc, out_data, out_valid, out_last, out_beat, out_par
    );
`else
    modport master (
        input  rdata, rempty, out_ready,
        output rinc, out_data, out_valid, out_last, out_beat
    );
    modport slave (
        output rdata, rempty, out_ready,
        input  rinc, out_data, out_valid, out_last, out_beat
    );
`endif

endinterface

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry in-order buffer between the FIFO head and the stream; r_head is always the word on offer.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_valid,
    output logic         o_space
);

    cnt_st_t        r_state;
    logic [W-1:0]   r_head;
    logic [W-1:0]   r_tail;

    // Flush wins over everything, so a pop seen in the same cycle is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (i_push && !i_pop) begin
                        r_tail  <= i_data;
                        r_state <= ST_FULL;
                    end else if (i_push && i_pop) begin
                        r_head  <= i_data;
                    end else if (i_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail  <= i_data;
                        else        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_state != ST_EMPTY);
    assign o_space = (r_state != ST_FULL) | i_pop;

endmodule

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read-side consumer: pops into a 2-deep buffer and streams out with burst beat/last tags.
// Define FIFO_RD_PARITY_EN to carry a per-word even-parity bit through to out_par.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  flush,
    fifo_rd_stream_if.master      bus
);

    localparam int                BEAT_W    = beat_w(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

`ifdef FIFO_RD_PARITY_EN
    localparam int W = DSIZE + 1;
`else
    localparam int W = DSIZE;
`endif

    logic              w_fire;
    logic              w_pop;
    logic              w_space;
    logic              w_valid;
    logic [W-1:0]      w_head;
    logic [W-1:0]      w_push_data;
    logic [BEAT_W-1:0] r_beat;

    // Reset is folded in so the FIFO is never popped while the buffer is held cleared.
    assign w_fire = w_valid & bus.out_ready;
    assign w_pop  = rrst_n & ~bus.rempty & w_space & ~flush;

`ifdef FIFO_RD_PARITY_EN
    assign w_push_data = {^bus.rdata, bus.rdata};
    assign bus.out_par = w_head[DSIZE];
`else
    assign w_push_data = bus.rdata;
`endif

    fifo_rd_skid #(.W(W)) u_skid (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .i_flush (flush),
        .i_push  (w_pop),
        .i_data  (w_push_data),
        .i_pop   (w_fire),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_space (w_space)
    );

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_beat <= '0;
        end else if (flush) begin
            r_beat <= '0;
        end else if (w_fire) begin
            r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + BEAT_W'(1);
        end
    end

    assign bus.rinc      = w_pop;
    assign bus.out_data  = w_head[DSIZE-1:0];
    assign bus.out_valid = w_valid;
    assign bus.out_beat  = r_beat;
    assign bus.out_last  = w_valid & (r_beat == BEAT_LAST);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a vector table for the plain burst, hand sequences for stall, flush and reset.
module tb_fifo_rd_stream;

    typedef struct {
        logic       empty;
        logic [7:0] data;
        logic       ready;
        logic       fl;
        logic       expRinc;
        logic       expValid;
        logic [7:0] expData;
        logic [2:0] expBeat;
        logic       expLast;
    } vec_t;

    logic clk;
    logic rstN;
    logic flush;
    int   errCount;
    int   checkCount;

    fifo_rd_stream_if #(.DSIZE(8), .BURST_LEN(8)) bus ();

    fifo_rd_stream #(.DSIZE(8), .BURST_LEN(8)) dut (
        .rclk   (clk),
        .rrst_n (rstN),
        .flush  (flush),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic empty, input logic [7:0] data, input logic ready,
                                input logic fl, input logic expRinc, input logic expValid,
                                input logic [7:0] expData, input logic [2:0] expBeat,
                                input logic expLast);
        vec_t v;
        v.empty    = empty;
        v.data     = data;
        v.ready    = ready;
        v.fl       = fl;
        v.expRinc  = expRinc;
        v.expValid = expValid;
        v.expData  = expData;
        v.expBeat  = expBeat;
        v.expLast  = expLast;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive, check the combinational pop, then check registered state one edge later.
    task automatic applyStimulus(input vec_t v, input string tag);
        bus.rempty    = v.empty;
        bus.rdata     = v.data;
        bus.out_ready = v.ready;
        flush         = v.fl;
        #1;
        checkOutput({tag, " rinc"}, 32'(bus.rinc), 32'(v.expRinc));
        @(negedge clk);
        checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'(v.expValid));
        checkOutput({tag, " beat"}, 32'(bus.out_beat), 32'(v.expBeat));
        checkOutput({tag, " last"}, 32'(bus.out_last), 32'(v.expLast));
        if (v.expValid)
            checkOutput({tag, " data"}, 32'(bus.out_data), 32'(v.expData));
    endtask

    vec_t burstVecs[9];

    initial begin
        errCount   = 0;
        checkCount = 0;

        // Eight back-to-back words A1..A8 with the sink always ready, then the FIFO runs dry.
        for (int i = 0; i < 8; i++)
            burstVecs[i] = mk(1'b0, 8'hA1 + 8'(i), 1'b1, 1'b0, 1'b1, 1'b1,
                              8'hA1 + 8'(i), 3'(i), (i == 7));
        burstVecs[8] = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

        rstN          = 1'b0;
        flush         = 1'b0;
        bus.rempty    = 1'b0;
        bus.rdata     = 8'hA1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset rinc", 32'(bus.rinc), 32'd0);
        checkOutput("reset valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset beat", 32'(bus.out_beat), 32'd0);
        checkOutput("reset last", 32'(bus.out_last), 32'd0);
        checkOutput("reset data", 32'(bus.out_data), 32'd0);
        rstN = 1'b1;

        for (int i = 0; i < 9; i++)
            applyStimulus(burstVecs[i], $sformatf("burst%0d", i));

        // Stalled sink: two pops fill the buffer, then the head B1 holds until ready returns.
        applyStimulus(mk(1'b0, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 3'd0, 1'b0), "stall0");
        applyStimulus(mk(1'b0, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 3'd0, 1'b0), "stall1");
        applyStimulus(mk(1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 3'd0, 1'b0), "stall2");
        applyStimulus(mk(1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 3'd0, 1'b0), "stall3");
        // Full buffer, one ready cycle: fire and pop together, so the buffer stays full.
        applyStimulus(mk(1'b0, 8'hB3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 3'd1, 1'b0), "fullfire");
        applyStimulus(mk(1'b0, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 3'd1, 1'b0), "stillfull");
        applyStimulus(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB3, 3'd2, 1'b0), "drain0");
        applyStimulus(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0), "drain1");

        // Flush while beat 3 is on offer: no pop, fire ignored, counter back to zero.
        applyStimulus(mk(1'b0, 8'hC1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC1, 3'd3, 1'b0), "preflush");
        applyStimulus(mk(1'b0, 8'hC2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0), "flush");
        applyStimulus(mk(1'b0, 8'hC2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC2, 3'd0, 1'b0), "postflush");
        applyStimulus(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0), "postdrain");

        // Reset with a word buffered: the word is dropped and popping stops immediately.
        applyStimulus(mk(1'b0, 8'hD1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hD1, 3'd1, 1'b0), "prereset");
        bus.rdata = 8'hD2;
        rstN      = 1'b0;
        #1;
        checkOutput("midreset rinc", 32'(bus.rinc), 32'd0);
        checkOutput("midreset valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset beat", 32'(bus.out_beat), 32'd0);
        checkOutput("midreset data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

`ifdef FIFO_RD_PARITY_EN
        applyStimulus(mk(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b0), "parA5");
        checkOutput("par A5", 32'(bus.out_par), 32'd0);
        applyStimulus(mk(1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 3'd1, 1'b0), "par07");
        checkOutput("par 07", 32'(bus.out_par), 32'd1);
        applyStimulus(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0), "pardrain");
`else
        applyStimulus(mk(1'b0, 8'hE1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE1, 3'd0, 1'b0), "restart");
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
